// File: rtl/hsstlp_apb_cfg_arbiter.sv
// Two-requester round-robin arbiter onto the HSSTLP APB config bridge; request in IDLE at n gives done at n+3 when ready is immediate.
// Bridge backpressure via p_cfg_ready stretches ACCESS up to TIMEOUT_CYCLES, then the transfer is aborted with err.
module hsstlp_apb_cfg_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        p_cfg_clk,
  input  logic        p_cfg_rst_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_done,
  output logic [7:0]  req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_done,
  output logic [7:0]  req1_rdata,
  output logic        req1_err,
  output logic        p_cfg_psel,
  output logic        p_cfg_enable,
  output logic        p_cfg_write,
  output logic [15:0] p_cfg_addr,
  output logic [7:0]  p_cfg_wdata,
  input  logic        p_cfg_ready,
  input  logic [7:0]  p_cfg_rdata,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       gnt;
  logic       last_gnt;
  logic [9:0] wait_cnt;
  logic       pick1;
  logic       timed_out;
  logic       finish;
  logic [7:0] fin_rdata;

  // last_gnt=1 means req1 was served last, so req0 wins a tie.
  always_comb begin
    pick1     = req1_valid && (!req0_valid || !last_gnt);
    timed_out = !p_cfg_ready && (wait_cnt == WAIT_LAST);
    finish    = p_cfg_ready || timed_out;
    fin_rdata = (p_cfg_ready && !p_cfg_write) ? p_cfg_rdata : 8'h00;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge p_cfg_clk) begin
    if (!p_cfg_rst_n) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      last_gnt     <= 1'b1;
      wait_cnt     <= '0;
      p_cfg_psel   <= 1'b0;
      p_cfg_enable <= 1'b0;
      p_cfg_write  <= 1'b0;
      p_cfg_addr   <= '0;
      p_cfg_wdata  <= '0;
      req0_done    <= 1'b0;
      req0_rdata   <= '0;
      req0_err     <= 1'b0;
      req1_done    <= 1'b0;
      req1_rdata   <= '0;
      req1_err     <= 1'b0;
      timeout_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt          <= pick1;
            last_gnt     <= pick1;
            p_cfg_write  <= pick1 ? req1_write : req0_write;
            p_cfg_addr   <= pick1 ? req1_addr  : req0_addr;
            p_cfg_wdata  <= pick1 ? req1_wdata : req0_wdata;
            p_cfg_psel   <= 1'b1;
            p_cfg_enable <= 1'b0;
            state        <= SETUP;
          end
        end
        SETUP: begin
          p_cfg_enable <= 1'b1;
          wait_cnt     <= '0;
          state        <= ACCESS;
        end
        ACCESS: begin
          if (!p_cfg_ready) wait_cnt <= wait_cnt + 10'd1;
          if (finish) begin
            p_cfg_psel   <= 1'b0;
            p_cfg_enable <= 1'b0;
            req0_done    <= !gnt;
            req1_done    <= gnt;
            req0_rdata   <= gnt ? 8'h00 : fin_rdata;
            req1_rdata   <= gnt ? fin_rdata : 8'h00;
            req0_err     <= !gnt && timed_out;
            req1_err     <= gnt && timed_out;
            if (timed_out && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state        <= DONE;
          end
        end
        DONE: begin
          req0_done  <= 1'b0;
          req0_rdata <= '0;
          req0_err   <= 1'b0;
          req1_done  <= 1'b0;
          req1_rdata <= '0;
          req1_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
